// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: prioritised, maskable multi-channel interrupt/reset
// sequencer for the 65CE02-family core. It requests interrupt injection at
// instruction boundaries (mc_sync), supplies the vector bytes and holds PC
// while the core runs its BRK-style entry microcode.
//
// Optional build macro: IRQ_VECTOR_CTRL_SYNC_EN
//   defined   -> irq[] and nmi pass through two-flop synchronisers (+2 clk)
//   undefined -> irq[] and nmi are taken as synchronous to clk
module irq_vector_ctrl #(
   parameter int unsigned NUM_IRQ = 4,
   parameter logic [15:0] EXT_VEC = 16'hFFE0,
   localparam int unsigned CW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ready,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               nmi,
   input  logic               mc_sync,
   input  logic               i_flag,
   input  logic               vec_ack,
   input  logic               mask_we,
   input  logic [NUM_IRQ-1:0] mask_d,
   output logic               intg,
   output logic               nmig,
   output logic               resp,
   output logic               pc_hold,
   output logic [7:0]         vector_hi,
   output logic [7:0]         vector_lo,
   output logic [CW-1:0]      irq_chan,
   output logic [NUM_IRQ-1:0] irq_mask,
   output logic [NUM_IRQ-1:0] irq_pend
);

   typedef enum logic [1:0] {
      ST_RST_SEQ = 2'd0,
      ST_IDLE    = 2'd1,
      ST_TAKEN   = 2'd2
   } state_e;

   localparam logic [15:0] VEC_RESET = 16'hFFFC;
   localparam logic [15:0] VEC_NMI   = 16'hFFFA;
   localparam logic [15:0] VEC_IRQ0  = 16'hFFFE;

   // Lowest set index of the request vector (bit 0 is highest priority).
   function automatic logic [CW-1:0] lowest_set(input logic [NUM_IRQ-1:0] req);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = CW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Vector for a channel; the low byte wraps without carrying into the high byte.
   function automatic logic [15:0] chan_vector(input logic [CW-1:0] chan);
      logic [7:0] chan8;
      logic [7:0] lo;
      chan8 = {{(8-CW){1'b0}}, chan};
      lo    = EXT_VEC[7:0] + {chan8[6:0], 1'b0} - 8'd2;
      if (chan == '0) begin
         return VEC_IRQ0;
      end else begin
         return {EXT_VEC[15:8], lo};
      end
   endfunction

   logic [NUM_IRQ-1:0] irq_src_s;
   logic               nmi_src_s;

`ifdef IRQ_VECTOR_CTRL_SYNC_EN
   logic [NUM_IRQ-1:0] irq_s1_q, irq_s2_q;
   logic               nmi_s1_q, nmi_s2_q;

   // Two-flop synchronisers for asynchronous request sources.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_s1_q <= '0;
         irq_s2_q <= '0;
         nmi_s1_q <= 1'b0;
         nmi_s2_q <= 1'b0;
      end else begin
         irq_s1_q <= irq;
         irq_s2_q <= irq_s1_q;
         nmi_s1_q <= nmi;
         nmi_s2_q <= nmi_s1_q;
      end
   end

   assign irq_src_s = irq_s2_q;
   assign nmi_src_s = nmi_s2_q;
`else
   assign irq_src_s = irq;
   assign nmi_src_s = nmi;
`endif

   state_e             state_q, state_d;
   logic               intg_q, intg_d;
   logic               nmig_q, nmig_d;
   logic               resp_q, resp_d;
   logic               pc_hold_q, pc_hold_d;
   logic [15:0]        vector_q, vector_d;
   logic [CW-1:0]      chan_q, chan_d;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pend_q;
   logic               nmi_prev_q;
   logic               nmi_pend_q, nmi_pend_d;
   logic               nmi_rise_s;
   logic               take_nmi_s;

   assign nmi_rise_s = nmi_src_s & ~nmi_prev_q;
   // A fresh edge wins over the clear from taking the previous NMI.
   assign nmi_pend_d = nmi_rise_s | (nmi_pend_q & ~take_nmi_s);

   // Next-state and next-output decision; everything holds unless ready.
   always_comb begin
      state_d    = state_q;
      intg_d     = intg_q;
      nmig_d     = nmig_q;
      resp_d     = resp_q;
      pc_hold_d  = pc_hold_q;
      vector_d   = vector_q;
      chan_d     = chan_q;
      take_nmi_s = 1'b0;
      case (state_q)
         ST_RST_SEQ: begin
            if (ready && vec_ack) begin
               state_d   = ST_IDLE;
               intg_d    = 1'b0;
               nmig_d    = 1'b0;
               resp_d    = 1'b0;
               pc_hold_d = 1'b0;
            end else begin
               state_d = ST_RST_SEQ;
            end
         end
         ST_IDLE: begin
            if (ready && mc_sync) begin
               if (nmi_pend_q) begin
                  state_d    = ST_TAKEN;
                  intg_d     = 1'b1;
                  pc_hold_d  = 1'b1;
                  nmig_d     = 1'b1;
                  vector_d   = VEC_NMI;
                  take_nmi_s = 1'b1;
               end else if ((pend_q != '0) && !i_flag) begin
                  state_d   = ST_TAKEN;
                  intg_d    = 1'b1;
                  pc_hold_d = 1'b1;
                  nmig_d    = 1'b0;
                  chan_d    = lowest_set(pend_q);
                  vector_d  = chan_vector(lowest_set(pend_q));
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TAKEN: begin
            if (ready && vec_ack) begin
               state_d   = ST_IDLE;
               intg_d    = 1'b0;
               nmig_d    = 1'b0;
               pc_hold_d = 1'b0;
            end else begin
               state_d = ST_TAKEN;
            end
         end
         default: begin
            state_d   = ST_RST_SEQ;
            intg_d    = 1'b1;
            nmig_d    = 1'b0;
            resp_d    = 1'b1;
            pc_hold_d = 1'b1;
            vector_d  = VEC_RESET;
            chan_d    = '0;
         end
      endcase
   end

   // FSM state and registered sequencer outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_RST_SEQ;
         intg_q    <= 1'b1;
         nmig_q    <= 1'b0;
         resp_q    <= 1'b1;
         pc_hold_q <= 1'b1;
         vector_q  <= VEC_RESET;
         chan_q    <= '0;
      end else begin
         state_q   <= state_d;
         intg_q    <= intg_d;
         nmig_q    <= nmig_d;
         resp_q    <= resp_d;
         pc_hold_q <= pc_hold_d;
         vector_q  <= vector_d;
         chan_q    <= chan_d;
      end
   end

   // Request capture and mask register; these run regardless of ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q     <= '1;
         pend_q     <= '0;
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
      end else begin
         if (mask_we) begin
            mask_q <= mask_d;
         end else begin
            mask_q <= mask_q;
         end
         pend_q     <= irq_src_s & mask_q;
         nmi_prev_q <= nmi_src_s;
         nmi_pend_q <= nmi_pend_d;
      end
   end

   assign intg      = intg_q;
   assign nmig      = nmig_q;
   assign resp      = resp_q;
   assign pc_hold   = pc_hold_q;
   assign vector_hi = vector_q[15:8];
   assign vector_lo = vector_q[7:0];
   assign irq_chan  = chan_q;
   assign irq_mask  = mask_q;
   assign irq_pend  = pend_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Self-checking bench for irq_vector_ctrl (default build, NUM_IRQ=4).
// Each step drives inputs, pushes the expected post-edge outputs onto a
// scoreboard queue, and pops/compares them #1 after the next rising edge.
module tb_irq_vector_ctrl;

   typedef struct packed {
      logic       rdy;
      logic [3:0] irq;
      logic       nmi;
      logic       mc;
      logic       ifl;
      logic       ack;
      logic       mwe;
      logic [3:0] md;
   } in_t;

   typedef struct packed {
      logic        intg;
      logic        nmig;
      logic        resp;
      logic        pch;
      logic [15:0] vec;
      logic [1:0]  chan;
      logic [3:0]  pend;
      logic [3:0]  mask;
   } exp_t;

   typedef struct packed {
      in_t  in;
      exp_t ex;
   } vec_t;

   localparam int NV = 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       ready, nmi, mc_sync, i_flag, vec_ack, mask_we;
   logic [3:0] irq, mask_d;
   logic       intg, nmig, resp, pc_hold;
   logic [7:0] vector_hi, vector_lo;
   logic [1:0] irq_chan;
   logic [3:0] irq_mask, irq_pend;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   vec_t tbl[NV];

   irq_vector_ctrl #(.NUM_IRQ(4), .EXT_VEC(16'hFFE0)) dut (
      .clk(clk), .reset(reset), .ready(ready), .irq(irq), .nmi(nmi),
      .mc_sync(mc_sync), .i_flag(i_flag), .vec_ack(vec_ack),
      .mask_we(mask_we), .mask_d(mask_d), .intg(intg), .nmig(nmig),
      .resp(resp), .pc_hold(pc_hold), .vector_hi(vector_hi),
      .vector_lo(vector_lo), .irq_chan(irq_chan), .irq_mask(irq_mask),
      .irq_pend(irq_pend)
   );

   always #5 clk = ~clk;

   function automatic vec_t row(
      input logic rdy, input logic [3:0] iq, input logic nm, input logic mc,
      input logic ifl, input logic ack, input logic mwe, input logic [3:0] md,
      input logic ei, input logic en, input logic er, input logic ep,
      input logic [15:0] ev, input logic [1:0] ec, input logic [3:0] epd,
      input logic [3:0] emk);
      vec_t v;
      v.in = '{rdy: rdy, irq: iq, nmi: nm, mc: mc, ifl: ifl, ack: ack, mwe: mwe, md: md};
      v.ex = '{intg: ei, nmig: en, resp: er, pch: ep, vec: ev, chan: ec, pend: epd, mask: emk};
      return v;
   endfunction

   task automatic drive(input in_t i);
      ready   = i.rdy;
      irq     = i.irq;
      nmi     = i.nmi;
      mc_sync = i.mc;
      i_flag  = i.ifl;
      vec_ack = i.ack;
      mask_we = i.mwe;
      mask_d  = i.md;
   endtask

   task automatic check_out(input string name);
      exp_t e;
      exp_t a;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, nothing to compare", name);
      end else begin
         e = exp_q.pop_front();
         a = '{intg: intg, nmig: nmig, resp: resp, pch: pc_hold,
               vec: {vector_hi, vector_lo}, chan: irq_chan, pend: irq_pend, mask: irq_mask};
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got intg=%b nmig=%b resp=%b pc_hold=%b vec=%h chan=%0d pend=%b mask=%b; need intg=%b nmig=%b resp=%b pc_hold=%b vec=%h chan=%0d pend=%b mask=%b",
                     name, a.intg, a.nmig, a.resp, a.pch, a.vec, a.chan, a.pend, a.mask,
                     e.intg, e.nmig, e.resp, e.pch, e.vec, e.chan, e.pend, e.mask);
         end
      end
   endtask

   task automatic step(input vec_t v, input string name);
      drive(v.in);
      exp_q.push_back(v.ex);
      @(posedge clk);
      #1;
      check_out(name);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            rdy   irq    nmi   mc    ifl   ack   mwe   md       intg  nmig  resp  pch   vec        ch     pend   mask
      tbl[0]  = row(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 2'd0, 4'h0, 4'hF);
      tbl[1]  = row(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 2'd0, 4'h4, 4'hF);
      tbl[2]  = row(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 2'd0, 4'h4, 4'hF);
      tbl[3]  = row(1'b1, 4'h4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 1'b1, 16'hFFE2, 2'd2, 4'h4, 4'hF);
      tbl[4]  = row(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 1'b1, 16'hFFE2, 2'd2, 4'h0, 4'hF);
      tbl[5]  = row(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE2, 2'd2, 4'h0, 4'hF);
      tbl[6]  = row(1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE2, 2'd2, 4'h6, 4'hF);
      tbl[7]  = row(1'b1, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd2, 4'h6, 4'hF);
      tbl[8]  = row(1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd2, 4'h6, 4'hF);
      tbl[9]  = row(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 1'b1, 16'hFFE0, 2'd1, 4'h6, 4'hF);
      tbl[10] = row(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE0, 2'd1, 4'h0, 4'hF);
      tbl[11] = row(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE0, 2'd1, 4'h1, 4'hF);
      tbl[12] = row(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE0, 2'd1, 4'h1, 4'hF);
      tbl[13] = row(1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE0, 2'd1, 4'h1, 4'hF);
      tbl[14] = row(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd1, 4'h1, 4'hF);
      tbl[15] = row(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h1, 4'hF);
      tbl[16] = row(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h0, 4'hF);
      tbl[17] = row(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h0, 4'hF);
      tbl[18] = row(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd1, 4'h0, 4'hF);
      tbl[19] = row(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hE,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd1, 4'h0, 4'hE);
      tbl[20] = row(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h0, 4'hE);
      tbl[21] = row(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h0, 4'hE);
      tbl[22] = row(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFA, 2'd1, 4'h8, 4'hF);
      tbl[23] = row(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 1'b1, 16'hFFE4, 2'd3, 4'h8, 4'hF);
      tbl[24] = row(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE4, 2'd3, 4'h8, 4'hF);
      tbl[25] = row(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b0, 1'b0, 1'b1, 16'hFFE4, 2'd3, 4'h8, 4'hF);
      tbl[26] = row(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,   1'b0, 1'b0, 1'b0, 1'b0, 16'hFFE4, 2'd3, 4'h0, 4'hF);
      tbl[27] = row(1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd3, 4'h0, 4'hF);
      tbl[28] = row(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd3, 4'h0, 4'h3);
      tbl[29] = row(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFA, 2'd3, 4'h0, 4'h3);

      // Reset held across several edges: reset values must be present.
      reset = 1'b0;
      drive(in_t'(0));
      ready = 1'b1;
      exp_q.push_back('{intg: 1'b1, nmig: 1'b0, resp: 1'b1, pch: 1'b1, vec: 16'hFFFC,
                        chan: 2'd0, pend: 4'h0, mask: 4'hF});
      repeat (3) @(posedge clk);
      #1;
      check_out("reset_hold");
      reset = 1'b1;

      // Main table: reset sequence, takes, priority, i_flag, ready, mask, back-to-back.
      for (int i = 0; i < NV; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Asynchronous reset mid-NMI sequence with an NMI still pending.
      #2;
      exp_q.push_back('{intg: 1'b1, nmig: 1'b0, resp: 1'b1, pch: 1'b1, vec: 16'hFFFC,
                        chan: 2'd0, pend: 4'h0, mask: 4'hF});
      drive(in_t'(0));
      ready = 1'b1;
      reset = 1'b0;
      #1;
      check_out("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // After release: RST_SEQ ignores mc_sync, exits on vec_ack, and no stale NMI is taken.
      step(row(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,
               1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 2'd0, 4'h0, 4'hF), "post_rst_hold");
      step(row(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 2'd0, 4'h0, 4'hF), "post_rst_ack");
      step(row(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 2'd0, 4'h0, 4'hF), "post_rst_no_nmi");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
